// File: rtl/test_result_monitor_if.sv
// rtl/test_result_monitor_if.sv - control, retire-trace and result signals of the riscv-tests result monitor
// Purpose: bundles everything between a testbench/harness (master) and the monitor (slave).
// Ports:
//   start, clear      master->slave  one-cycle control pulses
//   retire, pc, gp    master->slave  retire trace: commit strobe, retiring PC, current x3
//   busy, done        slave->master  RUN / DONE status
//   pass, timeout     slave->master  result flags
//   fail_test         slave->master  gp[31:1] of a failing end-hit, else 0
//   cycle_count       slave->master  RUN cycles elapsed
interface test_result_monitor_if;
  logic        start;
  logic        clear;
  logic        retire;
  logic [31:0] pc;
  logic [31:0] gp;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [30:0] fail_test;
  logic [31:0] cycle_count;

  modport master (
    output start, clear, retire, pc, gp,
    input  busy, done, pass, timeout, fail_test, cycle_count
  );

  modport slave (
    input  start, clear, retire, pc, gp,
    output busy, done, pass, timeout, fail_test, cycle_count
  );
endinterface

// File: rtl/test_result_monitor.sv
// rtl/test_result_monitor.sv - watches a RISC-V retire trace for the riscv-tests pass/fail ecall
// Purpose: once armed, counts RUN cycles until the core retires the instruction at END_PC
//   (result taken from gp) or until TIMEOUT cycles pass; the result is held until clear.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  test_result_monitor_if.slave (start/clear/retire/pc/gp in; busy/done/pass/timeout/fail_test/cycle_count out)
module test_result_monitor #(
  parameter logic [31:0] END_PC     = 32'h44,
  parameter int unsigned TIMEOUT    = 5000,
  parameter logic [31:0] PASS_VALUE = 32'h1
) (
  input  logic                 clk,
  input  logic                 rst,
  test_result_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // cycle_count still holds the previous value during the cycle being judged,
  // so the last allowed cycle is the one where it reads TIMEOUT-1.
  localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT) - 32'd1;

  state_t      state;
  state_t      state_next;
  logic        end_hit;
  logic        time_up;
  logic        gp_is_pass;
  logic [31:0] count_q;
  logic        pass_q;
  logic        timeout_q;
  logic [30:0] fail_q;

  assign end_hit    = bus.retire && (bus.pc == END_PC);
  assign time_up    = (count_q == LAST_CYCLE);
  assign gp_is_pass = (bus.gp == PASS_VALUE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; end-hit is tested before timeout so it wins a same-cycle race.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (end_hit || time_up) state_next = DONE;
      DONE:    if (bus.clear) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Cycle counter and result registers. gp is captured only on the end-hit
  // cycle; in DONE nothing but clear touches the results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= 32'd0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      fail_q    <= 31'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            count_q   <= 32'd0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            fail_q    <= 31'd0;
          end
        end
        RUN: begin
          if (count_q != 32'hFFFF_FFFF) begin
            count_q <= count_q + 32'd1;
          end
          if (end_hit) begin
            pass_q    <= gp_is_pass;
            timeout_q <= 1'b0;
            fail_q    <= gp_is_pass ? 31'd0 : bus.gp[31:1];
          end else if (time_up) begin
            pass_q    <= 1'b0;
            timeout_q <= 1'b1;
            fail_q    <= 31'd0;
          end
        end
        DONE: begin
          // cycle_count is deliberately kept until the next start
          if (bus.clear) begin
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            fail_q    <= 31'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pass        = pass_q;
  assign bus.timeout     = timeout_q;
  assign bus.fail_test   = fail_q;
  assign bus.cycle_count = count_q;

endmodule

// File: tb/tb_test_result_monitor.sv
// tb/tb_test_result_monitor.sv - directed and randomized checks of test_result_monitor against a scenario model
module tb_test_result_monitor;

  localparam int unsigned TO      = 16;
  localparam logic [31:0] END     = 32'h44;
  localparam logic [31:0] PASSV   = 32'h1;

  logic        clk;
  logic        rst;
  logic        start;
  logic        clear;
  logic        retire;
  logic [31:0] pc;
  logic [31:0] gp;

  int vectors;
  int miscompares;

  test_result_monitor_if bus_a ();
  test_result_monitor_if bus_b ();

  assign bus_a.start  = start;
  assign bus_a.clear  = clear;
  assign bus_a.retire = retire;
  assign bus_a.pc     = pc;
  assign bus_a.gp     = gp;
  assign bus_b.start  = start;
  assign bus_b.clear  = clear;
  assign bus_b.retire = retire;
  assign bus_b.pc     = pc;
  assign bus_b.gp     = gp;

  test_result_monitor #(.END_PC(END), .TIMEOUT(TO), .PASS_VALUE(PASSV)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  test_result_monitor dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    start  = 1'b0;
    clear  = 1'b0;
    retire = 1'b0;
    pc     = 32'h0;
    gp     = 32'h0;
  endtask

  // Random retire traffic that is never an end-hit; may carry pc==END with retire=0.
  task automatic noise(input bit allow_ctl);
    retire = ($urandom_range(0, 1) == 1);
    if (retire) pc = $urandom() | 32'h1000;
    else        pc = ($urandom_range(0, 1) == 1) ? END : $urandom();
    gp = $urandom();
    if (allow_ctl) begin
      start = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic end_hit(input logic [31:0] value);
    retire = 1'b1;
    pc     = END;
    gp     = value;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'd0, bus_a.busy}, 32'd0);
    check({tag, "_done"},  {31'd0, bus_a.done}, 32'd0);
    check({tag, "_pass"},  {31'd0, bus_a.pass}, 32'd0);
    check({tag, "_to"},    {31'd0, bus_a.timeout}, 32'd0);
    check({tag, "_fail"},  {1'b0, bus_a.fail_test}, 32'd0);
    check({tag, "_count"}, bus_a.cycle_count, 32'd0);
  endtask

  int          hit;
  int          term;
  logic [31:0] hit_gp;
  logic        exp_pass;
  logic        exp_to;
  logic [30:0] exp_fail;

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle_inputs();

    // Reset, including reset winning over start and an end-hit
    rst = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    start = 1'b1;
    end_hit(PASSV);
    tick();
    check("reset_over_start_busy", {31'd0, bus_a.busy}, 32'd0);
    check("reset_over_start_done", {31'd0, bus_a.done}, 32'd0);
    idle_inputs();
    rst = 1'b1;
    tick();

    // Pass at RUN cycle 21 on the default-TIMEOUT instance; the TIMEOUT=16
    // instance sees the same trace, pc==END without retire, and times out.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", {31'd0, bus_b.busy}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      retire = 1'b0;
      pc     = END;
      gp     = PASSV;
      tick();
      if (k == 15) check("a_busy_before_timeout", {30'd0, bus_a.busy, bus_a.done}, 32'd2);
      if (k == 16) begin
        check("a_timeout_done", {30'd0, bus_a.busy, bus_a.done}, 32'd1);
        check("a_timeout_flag", {31'd0, bus_a.timeout}, 32'd1);
      end
    end
    check("b_still_running", {31'd0, bus_b.busy}, 32'd1);
    end_hit(PASSV);
    tick();
    idle_inputs();
    check("b_pass_done",  {31'd0, bus_b.done}, 32'd1);
    check("b_pass_busy",  {31'd0, bus_b.busy}, 32'd0);
    check("b_pass_pass",  {31'd0, bus_b.pass}, 32'd1);
    check("b_pass_to",    {31'd0, bus_b.timeout}, 32'd0);
    check("b_pass_fail",  {1'b0, bus_b.fail_test}, 32'd0);
    check("b_pass_count", bus_b.cycle_count, 32'd21);
    check("a_to_pass",    {31'd0, bus_a.pass}, 32'd0);
    check("a_to_fail",    {1'b0, bus_a.fail_test}, 32'd0);
    check("a_to_count",   bus_a.cycle_count, 32'd16);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("b_clear_done",  {31'd0, bus_b.done}, 32'd0);
    check("b_clear_pass",  {31'd0, bus_b.pass}, 32'd0);
    check("b_clear_count", bus_b.cycle_count, 32'd21);

    // Fail with gp=7, held until clear even as gp changes
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    end_hit(32'h7);
    tick();
    idle_inputs();
    check("fail_done", {31'd0, bus_a.done}, 32'd1);
    check("fail_pass", {31'd0, bus_a.pass}, 32'd0);
    check("fail_num",  {1'b0, bus_a.fail_test}, 32'd3);
    gp = 32'h1;
    repeat (3) tick();
    check("fail_held", {1'b0, bus_a.fail_test}, 32'd3);
    check("fail_held_done", {31'd0, bus_a.done}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("fail_cleared_done", {31'd0, bus_a.done}, 32'd0);

    // Race: end-hit in the 16th RUN cycle wins over timeout
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    end_hit(PASSV);
    tick();
    idle_inputs();
    check("race_pass",  {31'd0, bus_a.pass}, 32'd1);
    check("race_to",    {31'd0, bus_a.timeout}, 32'd0);
    check("race_count", bus_a.cycle_count, 32'd16);

    // start during RUN ignored; clear+start in DONE returns to IDLE only
    clear = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b1;
    tick();
    repeat (3) tick();
    start = 1'b0;
    end_hit(PASSV);
    tick();
    idle_inputs();
    check("restart_ignored_count", bus_a.cycle_count, 32'd4);
    clear = 1'b1;
    start = 1'b1;
    tick();
    idle_inputs();
    check("clr_start_busy", {30'd0, bus_a.busy, bus_a.done}, 32'd0);
    tick();
    check("clr_start_dropped", {31'd0, bus_a.busy}, 32'd0);

    // Reset mid-RUN at cycle 10 aborts; a later end-hit reports nothing
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_all_zero("abort");
    end_hit(32'h9);
    tick();
    idle_inputs();
    check("abort_no_done", {31'd0, bus_a.done}, 32'd0);
    check("abort_no_busy", {31'd0, bus_a.busy}, 32'd0);

    // Randomized scenarios: model picks the end-hit cycle (possibly past TIMEOUT)
    for (int s = 0; s < 40; s++) begin
      hit      = $urandom_range(1, TO + 3);
      hit_gp   = ($urandom_range(0, 1) == 1) ? PASSV : $urandom();
      term     = (hit <= int'(TO)) ? hit : int'(TO);
      exp_to   = (hit > int'(TO));
      exp_pass = !exp_to && (hit_gp == PASSV);
      exp_fail = (!exp_to && !exp_pass) ? hit_gp[31:1] : 31'd0;

      noise(1'b0);
      start = 1'b1;
      clear = 1'b0;
      tick();
      start = 1'b0;
      check("rnd_start_busy", {31'd0, bus_a.busy}, 32'd1);
      for (int k = 1; k <= term; k++) begin
        if (k == hit) begin
          end_hit(hit_gp);
          start = ($urandom_range(0, 1) == 1);
          clear = ($urandom_range(0, 1) == 1);
        end else begin
          noise(1'b1);
        end
        tick();
        check("rnd_exclusive", {31'd0, bus_a.busy & bus_a.done}, 32'd0);
        if (k < term) begin
          check("rnd_run_busy", {30'd0, bus_a.busy, bus_a.done}, 32'd2);
          check("rnd_run_count", bus_a.cycle_count, k);
        end
      end
      start = 1'b0;
      clear = 1'b0;
      check("rnd_done",  {30'd0, bus_a.busy, bus_a.done}, 32'd1);
      check("rnd_pass",  {31'd0, bus_a.pass}, {31'd0, exp_pass});
      check("rnd_to",    {31'd0, bus_a.timeout}, {31'd0, exp_to});
      check("rnd_fail",  {1'b0, bus_a.fail_test}, {1'b0, exp_fail});
      check("rnd_count", bus_a.cycle_count, term);
      for (int h = 0; h < 3; h++) begin
        noise(1'b0);
        if ($urandom_range(0, 1) == 1) end_hit($urandom());
        start = ($urandom_range(0, 1) == 1);
        tick();
        check("rnd_hold_done",  {31'd0, bus_a.done}, 32'd1);
        check("rnd_hold_pass",  {31'd0, bus_a.pass}, {31'd0, exp_pass});
        check("rnd_hold_fail",  {1'b0, bus_a.fail_test}, {1'b0, exp_fail});
        check("rnd_hold_count", bus_a.cycle_count, term);
      end
      noise(1'b0);
      clear = 1'b1;
      start = ($urandom_range(0, 1) == 1);
      tick();
      idle_inputs();
      check("rnd_clr_state", {30'd0, bus_a.busy, bus_a.done}, 32'd0);
      check("rnd_clr_res",   {bus_a.pass, bus_a.timeout, bus_a.fail_test}, 32'd0);
      check("rnd_clr_count", bus_a.cycle_count, term);
      tick();
      check("rnd_idle_busy", {31'd0, bus_a.busy}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
